podule_bus_master: RTL and testbench
====================================

// Module: podule_bus_master
// PURPOSE
//   Podule/IOC bus initiator: runs single 8-bit read or write cycles on A[13:2], nIOC_SEL, nRE, nWE, RnW, D.
//   Provides the host end of the bus that the board's top-level responder decodes.
//   Used for on-chip self-test loopback and as the synthesizable host in system benches.
//   A simple req/ack command port drives it; setup, strobe and hold phases have programmable length.
// PARAMETERS
//   SETUP_CYCLES   2   clk cycles with address/select valid before the strobe; legal range 1..15
//   STROBE_CYCLES  6   clk cycles with nRE/nWE low; legal range 3..15 (responder double-syncs strobes)
//   HOLD_CYCLES    2   clk cycles with address/select/data held after the strobe rises; legal range 1..15
//   CNT_W          4   phase counter width; must hold max(SETUP,STROBE,HOLD)
// PORTS
//   clk       in   1   main clock (FPGA_CLK domain)
//   reset     in   1   synchronous, active-high reset
//   req       in   1   command request, sampled only when busy=0
//   rnw       in   1   1=read, 0=write (sampled with req)
//   addr      in   12  word address bits [13:2] (sampled with req)
//   wdata     in   8   write data (sampled with req)
//   busy      out  1   transaction in progress
//   ack       out  1   one-cycle completion pulse
//   rdata     out  8   read data; valid from ack until the next accepted read
//   A         out  12  bus address [13:2]
//   nIOC_SEL  out  1   active-low select
//   nRE       out  1   active-low read strobe
//   nWE       out  1   active-low write strobe
//   RnW       out  1   bus direction, 1=read
//   D_out     out  8   bus write data
//   D_oe      out  1   D output enable (pad tristate is built outside this block)
//   D_in      in   8   bus read data
// BEHAVIOUR
//   - Every output is registered. After reset: busy=0, ack=0, rdata=0, A=0, nIOC_SEL=1, nRE=1, nWE=1, RnW=1, D_out=0, D_oe=0; FSM is in IDLE.
//   - FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. Each of SETUP, STROBE and HOLD lasts exactly its parameter in cycles, counted by a down-counter loaded on entry.
//   - IDLE: when req=1 at edge k, latch rnw, addr and wdata, and enter SETUP.
//     From edge k+1: busy=1, A=addr, nIOC_SEL=0, RnW=rnw; for writes, D_out=wdata and D_oe=1.
//   - STROBE: nRE=0 for reads, nWE=0 for writes. A, nIOC_SEL, RnW and D are stable throughout.
//   - Read capture: rdata is loaded from D_in on the clock edge that ends the last STROBE cycle.
//   - HOLD: both strobes are high. A, nIOC_SEL, RnW, D_out and D_oe are unchanged.
//   - Completion, cycle after the last HOLD cycle: ack=1 for exactly one cycle, busy=0, nIOC_SEL=1, D_oe=0, RnW=1. A keeps the last value.
//   - Latency: ack is high in cycle k+1+SETUP+STROBE+HOLD (defaults: k+11).
//   - Back-to-back: a req present in the ack cycle is accepted, so SETUP starts the next cycle. nIOC_SEL is high for exactly that one cycle.
//   - A req while busy=1 is ignored and is not queued. rnw, addr and wdata changes while busy have no effect.
//   - nRE and nWE are never low in the same cycle. No strobe is low while nIOC_SEL=1. D_oe=1 only while a write is in progress.
//   - Reset mid-transaction: on the next edge every output returns to its reset value and no ack is issued. rdata is cleared.
//   - Parameters out of range are a synthesis error, enforced by a generate-time check.
// STRUCTURE
//   - Shared include podule_defs.vh: state encodings (ST_IDLE=2'd0, ST_SETUP=2'd1, ST_STROBE=2'd2, ST_HOLD=2'd3) and parameter limits.
//   - One sub-module: bus_phase_timer (load, count value, done flag), instantiated once and reloaded on each phase entry.
// TESTING
//   1. Reset: hold reset 3 cycles with req=1 -> all outputs at reset values, busy=0, no bus activity.
//   2. Write: addr=12'h0A5, wdata=8'h3C, default params ->
//      nIOC_SEL low cycles 1-10, nWE low cycles 3-8, D_oe=1 cycles 1-10, ack in cycle 11.
//   3. Read: addr=12'h200, D_in=8'hE7 during STROBE only ->
//      rdata=8'hE7 at ack; nRE low for 6 cycles; D_oe stays 0.
//   4. Back-to-back: write then read, req held high -> second SETUP starts in the cycle after ack; nIOC_SEL high for 1 cycle between them.
//   5. Busy ignore: pulse req with addr=12'hFFF mid-STROBE -> A unchanged, only one ack issued.
//   6. Mid-op reset: assert reset in the 2nd STROBE cycle -> next cycle nWE=1, nIOC_SEL=1, D_oe=0, and ack never asserts.

Source files
------------

// File: rtl/podule_bus_master_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : podule_bus_master_pkg
//  Purpose  : Shared definitions for the podule/IOC bus initiator.
//             - FSM state encoding (IDLE/SETUP/STROBE/HOLD)
//             - Legal limits for the phase-length parameters
//             - Helper to find the longest phase (sizes the phase counter)
//  Revision : 1.0 - initial release
// ============================================================================
package podule_bus_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int SETUP_MIN  = 1;
  localparam int SETUP_MAX  = 15;
  // The responder double-synchronises the strobes, so a short strobe would be missed.
  localparam int STROBE_MIN = 3;
  localparam int STROBE_MAX = 15;
  localparam int HOLD_MIN   = 1;
  localparam int HOLD_MAX   = 15;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_phase_timer
//  Purpose  : Down-counter that times one bus phase. Loaded with the phase
//             length on phase entry; done_o is high during the last cycle of
//             the phase (count == 1).
//  Ports    : clk, reset   - clock, synchronous active-high reset
//             load_i       - reload the counter with load_val_i this edge
//             load_val_i   - phase length in cycles
//             done_o       - current cycle is the last one of the phase
//  Revision : 1.0 - initial release
// ============================================================================
module bus_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      // Parks at zero once a phase has expired and no new phase is loaded.
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/podule_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : podule_bus_master
//  Purpose  : Podule/IOC bus initiator. Runs single 8-bit read or write
//             cycles (SETUP -> STROBE -> HOLD) from a req/ack command port.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             req, rnw, addr,     - command (sampled only while idle)
//             wdata
//             busy, ack, rdata    - status / completion / read data
//             A, nIOC_SEL, nRE,   - bus address, select and strobes
//             nWE, RnW
//             D_out, D_oe, D_in   - bus data out / output enable / data in
//  Revision : 1.0 - initial release
// ============================================================================
module podule_bus_master
  import podule_bus_master_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 6,
  parameter int HOLD_CYCLES   = 2,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rnw,
  input  logic [11:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic [11:0] A,
  output logic        nIOC_SEL,
  output logic        nRE,
  output logic        nWE,
  output logic        RnW,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in
);

  // Elaboration-time legality check of the phase lengths and counter width.
  if (SETUP_CYCLES < SETUP_MIN || SETUP_CYCLES > SETUP_MAX ||
      STROBE_CYCLES < STROBE_MIN || STROBE_CYCLES > STROBE_MAX ||
      HOLD_CYCLES < HOLD_MIN || HOLD_CYCLES > HOLD_MAX ||
      max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) > ((1 << CNT_W) - 1)) begin : g_param_check
    $error("podule_bus_master: phase parameter out of range or CNT_W too small");
  end

  localparam logic [CNT_W-1:0] c_setup_len  = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] c_strobe_len = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] c_hold_len   = CNT_W'(HOLD_CYCLES);

  state_e           state_q;
  logic             busy_q, ack_q, sel_n_q, re_n_q, we_n_q, rnw_q, doe_q;
  logic [11:0]      a_q;
  logic [7:0]       dout_q, rdata_q;

  logic             tmr_load_d;
  logic [CNT_W-1:0] tmr_val_d;
  logic             tmr_done;

  // Reload the single shared timer whenever a new phase is entered.
  always_comb begin
    tmr_load_d = 1'b0;
    tmr_val_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = c_setup_len;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = c_strobe_len;
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = c_hold_len;
        end
      end
      default: ;
    endcase
  end

  bus_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load_d),
    .load_val_i (tmr_val_d),
    .done_o     (tmr_done)
  );

  // Single FSM; all bus and status outputs are registered here.
  // rnw_q doubles as the latched transaction direction while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      a_q     <= '0;
      sel_n_q <= 1'b1;
      re_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      rnw_q   <= 1'b1;
      dout_q  <= '0;
      doe_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q <= ST_SETUP;
            busy_q  <= 1'b1;
            a_q     <= addr;
            sel_n_q <= 1'b0;
            rnw_q   <= rnw;
            if (!rnw) begin
              dout_q <= wdata;
              doe_q  <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state_q <= ST_STROBE;
            if (rnw_q) re_n_q <= 1'b0;
            else       we_n_q <= 1'b0;
          end
        end
        ST_STROBE: begin
          if (tmr_done) begin
            state_q <= ST_HOLD;
            re_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            if (rnw_q) rdata_q <= D_in;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
            sel_n_q <= 1'b1;
            doe_q   <= 1'b0;
            rnw_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign A        = a_q;
  assign nIOC_SEL = sel_n_q;
  assign nRE      = re_n_q;
  assign nWE      = we_n_q;
  assign RnW      = rnw_q;
  assign D_out    = dout_q;
  assign D_oe     = doe_q;

endmodule
`default_nettype wire

// File: tb/tb_podule_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_podule_bus_master
//  Purpose  : Self-checking bench for podule_bus_master (default parameters).
//             Per-cycle vector table for reset, write (with a request while
//             busy) and read, then hand sequences for back-to-back and
//             mid-transaction reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_podule_bus_master;

  logic        clk = 1'b0;
  logic        reset, req, rnw;
  logic [11:0] addr;
  logic [7:0]  wdata, D_in;
  logic        busy, ack, nIOC_SEL, nRE, nWE, RnW, D_oe;
  logic [7:0]  rdata, D_out;
  logic [11:0] A;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  podule_bus_master dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .rnw      (rnw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .ack      (ack),
    .rdata    (rdata),
    .A        (A),
    .nIOC_SEL (nIOC_SEL),
    .nRE      (nRE),
    .nWE      (nWE),
    .RnW      (RnW),
    .D_out    (D_out),
    .D_oe     (D_oe),
    .D_in     (D_in)
  );

  // Packed output snapshot: busy,ack,nIOC_SEL,nRE,nWE,RnW,D_oe,A,D_out,rdata
  typedef struct packed {
    logic        rst;
    logic        req;
    logic        rnw;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic [34:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [34:0] outs_now();
    return {busy, ack, nIOC_SEL, nRE, nWE, RnW, D_oe, A, D_out, rdata};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample away from the active edge; bus-safety rules
  // are checked on every sampled cycle.
  task automatic tick();
    logic ok;
    @(negedge clk);
    ok = !(nRE == 1'b0 && nWE == 1'b0) &&
         !((nRE == 1'b0 || nWE == 1'b0) && nIOC_SEL == 1'b1) &&
         !(D_oe == 1'b1 && (RnW == 1'b1 || busy == 1'b0));
    chk("bus_rules", {63'd0, ok}, 64'd1);
  endtask

  task automatic add(input logic r, input logic q, input logic d, input logic [11:0] ad,
                     input logic [7:0] wd, input logic [7:0] di,
                     input logic e_busy, input logic e_ack, input logic e_sel,
                     input logic e_nre, input logic e_nwe, input logic e_rnw,
                     input logic e_doe, input logic [11:0] e_a,
                     input logic [7:0] e_dout, input logic [7:0] e_rdata);
    vec_t v;
    v.rst = r; v.req = q; v.rnw = d; v.addr = ad; v.wdata = wd; v.din = di;
    v.exp = {e_busy, e_ack, e_sel, e_nre, e_nwe, e_rnw, e_doe, e_a, e_dout, e_rdata};
    vecs.push_back(v);
  endtask

  initial begin
    int cyc;
    int acks;
    bit seen;

    reset = 1'b1; req = 1'b1; rnw = 1'b0; addr = 12'h0A5; wdata = 8'h3C; D_in = 8'h11;

    // Each entry: inputs before an edge, expected outputs after it.
    // Reset held 3 cycles with req=1.
    for (int i = 0; i < 3; i++)
      add(1,1,0,12'h0A5,8'h3C,8'h11, 0,0,1,1,1,1,0,12'h000,8'h00,8'h00);
    // Write 0x3C to 0x0A5: cycles 1..12 after accept.
    add(0,1,0,12'h0A5,8'h3C,8'h11, 1,0,0,1,1,0,1,12'h0A5,8'h3C,8'h00); // c1 setup
    add(0,0,0,12'h0A5,8'h3C,8'h11, 1,0,0,1,1,0,1,12'h0A5,8'h3C,8'h00); // c2 setup
    add(0,0,0,12'h0A5,8'h3C,8'h11, 1,0,0,1,0,0,1,12'h0A5,8'h3C,8'h00); // c3 strobe
    add(0,0,0,12'h0A5,8'h3C,8'h11, 1,0,0,1,0,0,1,12'h0A5,8'h3C,8'h00); // c4
    add(0,1,1,12'hFFF,8'h00,8'h11, 1,0,0,1,0,0,1,12'h0A5,8'h3C,8'h00); // c5 req while busy
    add(0,0,0,12'h0A5,8'h3C,8'h11, 1,0,0,1,0,0,1,12'h0A5,8'h3C,8'h00); // c6
    add(0,0,0,12'h0A5,8'h3C,8'h11, 1,0,0,1,0,0,1,12'h0A5,8'h3C,8'h00); // c7
    add(0,0,0,12'h0A5,8'h3C,8'h11, 1,0,0,1,0,0,1,12'h0A5,8'h3C,8'h00); // c8
    add(0,0,0,12'h0A5,8'h3C,8'h11, 1,0,0,1,1,0,1,12'h0A5,8'h3C,8'h00); // c9 hold
    add(0,0,0,12'h0A5,8'h3C,8'h11, 1,0,0,1,1,0,1,12'h0A5,8'h3C,8'h00); // c10 hold
    add(0,0,0,12'h0A5,8'h3C,8'h11, 0,1,1,1,1,1,0,12'h0A5,8'h3C,8'h00); // c11 ack
    add(0,0,0,12'h0A5,8'h3C,8'h11, 0,0,1,1,1,1,0,12'h0A5,8'h3C,8'h00); // c12 idle
    // Read from 0x200; D_in=0xE7 only while strobe is low.
    add(0,1,1,12'h200,8'h00,8'h11, 1,0,0,1,1,1,0,12'h200,8'h3C,8'h00); // c1
    add(0,0,1,12'h200,8'h00,8'h11, 1,0,0,1,1,1,0,12'h200,8'h3C,8'h00); // c2
    add(0,0,1,12'h200,8'h00,8'h11, 1,0,0,0,1,1,0,12'h200,8'h3C,8'h00); // c3 strobe
    for (int i = 4; i <= 8; i++)
      add(0,0,1,12'h200,8'h00,8'hE7, 1,0,0,0,1,1,0,12'h200,8'h3C,8'h00); // c4..c8
    add(0,0,1,12'h200,8'h00,8'hE7, 1,0,0,1,1,1,0,12'h200,8'h3C,8'hE7); // c9 captured
    add(0,0,1,12'h200,8'h00,8'h11, 1,0,0,1,1,1,0,12'h200,8'h3C,8'hE7); // c10
    add(0,0,1,12'h200,8'h00,8'h11, 0,1,1,1,1,1,0,12'h200,8'h3C,8'hE7); // c11 ack
    add(0,0,1,12'h200,8'h00,8'h11, 0,0,1,1,1,1,0,12'h200,8'h3C,8'hE7); // c12

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; req = vecs[i].req; rnw = vecs[i].rnw;
      addr = vecs[i].addr; wdata = vecs[i].wdata; D_in = vecs[i].din;
      tick();
      chk($sformatf("vec%0d", i), {29'd0, outs_now()}, {29'd0, vecs[i].exp});
    end

    // Back-to-back: write then read with req held high.
    req = 1'b1; rnw = 1'b0; addr = 12'h123; wdata = 8'h99; D_in = 8'h6B;
    tick();
    chk("b2b_w_start", {63'd0, busy}, 64'd1);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick(); cyc++;
      seen = ack;
    end
    chk("b2b_w_ack_cycle", 64'(cyc), 64'd11);
    chk("b2b_sel_gap", {63'd0, nIOC_SEL}, 64'd1);
    rnw = 1'b1; addr = 12'h321;
    tick();
    chk("b2b_r_start", {51'd0, busy, nIOC_SEL, RnW, D_oe, A},
        {51'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h321});
    req = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick(); cyc++;
      seen = ack;
    end
    chk("b2b_r_ack_cycle", 64'(cyc), 64'd11);
    chk("b2b_r_rdata", {56'd0, rdata}, 64'h6B);

    // Mid-transaction reset in the 2nd strobe cycle of a write.
    req = 1'b1; rnw = 1'b0; addr = 12'h0F0; wdata = 8'h55;
    tick();
    req = 1'b0;
    tick(); tick(); tick();
    chk("rst_mid_strobe", {62'd0, nWE, D_oe}, {62'd0, 1'b0, 1'b1});
    reset = 1'b1;
    tick();
    chk("rst_mid_outs", {29'd0, outs_now()},
        {29'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 8'h00, 8'h00});
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ack) acks++;
    end
    chk("rst_no_ack", 64'(acks), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
